wfunc_mult_ctrl: RTL and testbench

- Sequencer that applies a complex window function to an AXI-Stream sample frame using the integer complex multiplier of the window_func datapath.
- Accepts input samples and steps a coefficient address counter through a window ROM, presenting each sample with its coefficient to the multiplier.
- Tracks valid/last through the multiplier pipeline, produces a backpressured output stream, and checks frame length.

---
 rtl/wfunc_mult_ctrl.sv | 179 +++++++++++++++++
 tb/tb_wfunc_mult_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfunc_mult_ctrl.sv
// -----------------------------------------------------------------------------
// wfunc_mult_ctrl
//   Sequencer that applies a complex window to an AXI-Stream sample frame. Each
//   accepted sample is presented to an external pipelined complex multiplier
//   together with the window coefficient read from a combinational ROM. Beat
//   valid/last flags travel alongside the multiplier pipeline, and the whole
//   pipeline advances only when the output stream can move.
//
//   Complex samples are packed as {re, im}, each DW-bit two's complement.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   s_tdata/tvalid/tlast/tready   input sample stream
//   coef_addr       window ROM address (ROM read is combinational)
//   coef_data       coefficient at coef_addr
//   mult_en         multiplier pipeline enable (global stall when low)
//   mult_a, mult_b  multiplier operands (sample, coefficient)
//   mult_z          multiplier result, PIPE_NUM enabled cycles after operands
//   m_tdata/tvalid/tlast/tready   windowed output stream
//   frame_err       one-cycle pulse when a frame's length disagrees with
//                   FRAME_LEN (early s_tlast or missing s_tlast)
//
// Optional build macro WFUNC_ERR_CNT_EN
//   Adds err_clr (input) and err_cnt[15:0] (output): a saturating count of
//   frame_err pulses, synchronously cleared by err_clr (clear wins).
// -----------------------------------------------------------------------------
module wfunc_mult_ctrl #(
    parameter int FRAME_LEN = 1024,
    parameter int PIPE_NUM  = 10,
    parameter int COEF_FRAC = 15,
    parameter int AW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1,
    parameter int DW        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2*DW-1:0] s_tdata,
    input  logic            s_tvalid,
    input  logic            s_tlast,
    output logic            s_tready,
    output logic [AW-1:0]   coef_addr,
    input  logic [2*DW-1:0] coef_data,
    output logic            mult_en,
    output logic [2*DW-1:0] mult_a,
    output logic [2*DW-1:0] mult_b,
    input  logic [2*DW-1:0] mult_z,
    output logic [2*DW-1:0] m_tdata,
    output logic            m_tvalid,
    output logic            m_tlast,
    input  logic            m_tready,
    output logic            frame_err
`ifdef WFUNC_ERR_CNT_EN
    ,
    input  logic            err_clr,
    output logic [15:0]     err_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       coef_addr_q, coef_addr_d;
    logic [PIPE_NUM-1:0] vpipe_q, vpipe_d;
    logic [PIPE_NUM-1:0] lpipe_q, lpipe_d;
    logic                frame_err_q, frame_err_d;

    logic                accept;
    logic                at_end;
    logic                beat_last;
    logic signed [DW-1:0] z_re, z_im;

    // Global stall: nothing moves while a valid output beat is blocked.
    assign mult_en  = m_tready | ~vpipe_q[PIPE_NUM-1];
    assign s_tready = mult_en;
    assign accept   = s_tvalid & mult_en;
    assign at_end   = (coef_addr_q == LAST_ADDR);

    // An early s_tlast still terminates the output frame, so the last flag is
    // the OR of the counter end and the source's own last.
    assign beat_last = accept & (at_end | s_tlast);

    assign mult_a    = s_tdata;
    assign mult_b    = coef_data;
    assign coef_addr = coef_addr_q;

    assign z_re    = mult_z[2*DW-1:DW];
    assign z_im    = mult_z[DW-1:0];
    assign m_tdata = {z_re >>> COEF_FRAC, z_im >>> COEF_FRAC};

    assign m_tvalid  = vpipe_q[PIPE_NUM-1];
    assign m_tlast   = lpipe_q[PIPE_NUM-1];
    assign frame_err = frame_err_q;

    always_comb begin
        state_d     = state_q;
        coef_addr_d = coef_addr_q;
        // Exactly one of the two error conditions can hold for a beat.
        frame_err_d = accept & (s_tlast ^ at_end);

        case (state_q)
            IDLE: begin
                // at_end is always true here when FRAME_LEN==1, keeping IDLE.
                if (accept && !at_end && !s_tlast) begin
                    coef_addr_d = AW'(1);
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (at_end || s_tlast) begin
                        coef_addr_d = '0;
                        state_d     = IDLE;
                    end else begin
                        coef_addr_d = coef_addr_q + AW'(1);
                    end
                end
            end
            default: begin
                coef_addr_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    // Flag pipes mirror the multiplier; a non-accepting enabled cycle shifts
    // in a bubble which never reaches m_tvalid.
    always_comb begin
        vpipe_d = vpipe_q;
        lpipe_d = lpipe_q;
        if (mult_en) begin
            vpipe_d = (vpipe_q << 1) | PIPE_NUM'(accept);
            lpipe_d = (lpipe_q << 1) | PIPE_NUM'(beat_last);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            coef_addr_q <= '0;
            vpipe_q     <= '0;
            lpipe_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            coef_addr_q <= coef_addr_d;
            vpipe_q     <= vpipe_d;
            lpipe_q     <= lpipe_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef WFUNC_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (frame_err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_wfunc_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wfunc_mult_ctrl
//   Bench for wfunc_mult_ctrl with FRAME_LEN=8, PIPE_NUM=4. Two instances share
//   all inputs: one with COEF_FRAC=0 and one with COEF_FRAC=15. The bench
//   supplies the window ROM and a pipelined complex multiplier, and keeps a
//   frame-level reference model (beat queue + coefficient index).
// -----------------------------------------------------------------------------
module tb_wfunc_mult_ctrl;

    localparam int FL = 8;
    localparam int PN = 4;

    typedef struct {
        int sre, sim, cre, cim;
        int e0re, e0im, e15re, e15im;
    } vec_t;

    typedef struct {
        logic [63:0] d0;
        logic [63:0] d15;
        logic        last;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [2:0]  coef_addr;
    logic [63:0] coef_data;
    logic        mult_en;
    logic [63:0] mult_a, mult_b, mult_z;
    logic [63:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic        frame_err;

    logic        s_tready2, mult_en2, m_tvalid2, m_tlast2, frame_err2;
    logic [2:0]  coef_addr2;
    logic [63:0] mult_a2, mult_b2, m_tdata2;
`ifdef WFUNC_ERR_CNT_EN
    logic        err_clr;
    logic [15:0] err_cnt, err_cnt2;
`endif

    logic [63:0] coef_rom [FL];
    logic [63:0] mstage [PN];

    int checks   = 0;
    int failures = 0;

    // reference model state
    exp_t        q[$];
    int          idx       = 0;
    logic        err_pend  = 1'b0;
    int          err_total = 0;
    int          cyc       = 0;
    logic        check_lat = 1'b0;
    logic        rnd_rdy   = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic        prev_last;
    logic [63:0] last_out, last_out2;

    wfunc_mult_ctrl #(.FRAME_LEN(FL), .PIPE_NUM(PN), .COEF_FRAC(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b), .mult_z(mult_z),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .frame_err(frame_err)
`ifdef WFUNC_ERR_CNT_EN
        , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
    );

    wfunc_mult_ctrl #(.FRAME_LEN(FL), .PIPE_NUM(PN), .COEF_FRAC(15)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready2),
        .coef_addr(coef_addr2), .coef_data(coef_data),
        .mult_en(mult_en2), .mult_a(mult_a2), .mult_b(mult_b2), .mult_z(mult_z),
        .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tlast(m_tlast2), .m_tready(m_tready),
        .frame_err(frame_err2)
`ifdef WFUNC_ERR_CNT_EN
        , .err_clr(err_clr), .err_cnt(err_cnt2)
`endif
    );

    function automatic logic [63:0] pack(input int re, input int im);
        return {re, im};
    endfunction

    function automatic logic [63:0] cmul(input logic [63:0] a, input logic [63:0] b);
        int     a_re, a_im, b_re, b_im;
        longint pr, pi;
        a_re = a[63:32]; a_im = a[31:0];
        b_re = b[63:32]; b_im = b[31:0];
        pr = longint'(a_re) * longint'(b_re) - longint'(a_im) * longint'(b_im);
        pi = longint'(a_re) * longint'(b_im) + longint'(a_im) * longint'(b_re);
        return {pr[31:0], pi[31:0]};
    endfunction

    function automatic logic [63:0] shr(input logic [63:0] p, input int sh);
        int r, i;
        r = p[63:32];
        i = p[31:0];
        return {r >>> sh, i >>> sh};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // clock, ROM, multiplier
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign coef_data = coef_rom[coef_addr];
    assign mult_z    = mstage[PN-1];

    always @(posedge clk) begin
        if (mult_en) begin
            for (int i = PN - 1; i > 0; i--) mstage[i] <= mstage[i-1];
            mstage[0] <= cmul(mult_a, mult_b);
        end
    end

    // random output backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) m_tready = ($urandom_range(0, 1) == 1);
        end
    end

    // monitor + reference model, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            q.delete();
            idx        = 0;
            err_pend   = 1'b0;
            err_total  = 0;
            prev_stall = 1'b0;
            check("reset m_tvalid", {63'd0, m_tvalid}, 64'd0);
        end else begin
            check("frame_err", {63'd0, frame_err}, {63'd0, err_pend});
            if (frame_err) err_total++;
            err_pend = 1'b0;

            if (prev_stall) begin
                check("stall m_tvalid", {63'd0, m_tvalid}, 64'd1);
                check("stall m_tdata", m_tdata, prev_data);
                check("stall m_tlast", {63'd0, m_tlast}, {63'd0, prev_last});
            end

            if (m_tvalid && m_tready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got data %0h with no beat outstanding", m_tdata);
                end else begin
                    e = q.pop_front();
                    check("m_tdata frac0", m_tdata, e.d0);
                    check("m_tdata frac15", m_tdata2, e.d15);
                    check("m_tlast", {63'd0, m_tlast}, {63'd0, e.last});
                    if (check_lat) check("latency", 64'(cyc - e.cyc), 64'(PN));
                end
                last_out  = m_tdata;
                last_out2 = m_tdata2;
            end
            prev_stall = m_tvalid & ~m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;

            if (s_tvalid && s_tready) begin
                check("coef_addr", {61'd0, coef_addr}, 64'(idx));
                e.d0   = shr(cmul(s_tdata, coef_rom[idx]), 0);
                e.d15  = shr(cmul(s_tdata, coef_rom[idx]), 15);
                e.last = (idx == FL - 1) || s_tlast;
                e.cyc  = cyc;
                q.push_back(e);
                err_pend = s_tlast != (idx == FL - 1);
                idx = (idx == FL - 1 || s_tlast) ? 0 : idx + 1;
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic l);
        int n;
        n = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_tready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: s_tready still 0 after %0d cycles", n);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain outstanding", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_rom(input int re, input int im);
        for (int i = 0; i < FL; i++) coef_rom[i] = pack(re, im);
    endtask

    initial begin
        vec_t vecs[7];
        int   e0;

        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   e0;

        vecs[0] = '{5, -9, 1, 0, 5, -9, 0, -1};
        vecs[1] = '{3, 4, 0, 1, -4, 3, -1, 0};
        vecs[2] = '{100, -7, 16384, 0, 1638400, -114688, 50, -4};
        vecs[3] = '{1, -1, -32768, 0, -32768, 32768, -1, 1};
        vecs[4] = '{7, 11, 3, -2, 43, 19, 0, 0};
        vecs[5] = '{-8, 6, -1, -1, 14, 2, 0, 0};
        vecs[6] = '{-65536, 65535, 32767, 0, -2147418112, 2147385345, -65534, 65533};

        for (int i = 0; i < PN; i++) mstage[i] = '0;
        set_rom(1, 0);
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b1;
`ifdef WFUNC_ERR_CNT_EN
        err_clr  = 1'b0;
`endif
        #2;
        check("reset coef_addr", {61'd0, coef_addr}, 64'd0);
        check("reset m_tlast", {63'd0, m_tlast}, 64'd0);
        check("reset frame_err", {63'd0, frame_err}, 64'd0);
        check("reset s_tready", {63'd0, s_tready}, 64'd1);
`ifdef WFUNC_ERR_CNT_EN
        check("reset err_cnt", {48'd0, err_cnt}, 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // table vectors: a full frame of one sample against one coefficient
        check_lat = 1'b1;
        foreach (vecs[v]) begin
            set_rom(vecs[v].cre, vecs[v].cim);
            for (int k = 0; k < FL; k++) send(pack(vecs[v].sre, vecs[v].sim), k == FL - 1);
            drain();
            check("table frac0", last_out, pack(vecs[v].e0re, vecs[v].e0im));
            check("table frac15", last_out2, pack(vecs[v].e15re, vecs[v].e15im));
        end

        // distinct samples, identity window, back-to-back
        set_rom(1, 0);
        for (int k = 0; k < FL; k++) send(pack(10 * k + 1, -k), k == FL - 1);
        drain();
        check("identity last out", last_out, pack(71, -7));

        // random window, random samples, random gaps and backpressure
        check_lat = 1'b0;
        for (int i = 0; i < FL; i++)
            coef_rom[i] = pack($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
        rnd_rdy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < FL; k++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send(pack($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768),
                     k == FL - 1);
            end
        end
        drain();
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        set_rom(1, 0);
        coef_rom[0] = pack(2, 0);

        // early last on the 5th beat, then a normal frame
        e0 = err_total;
        for (int k = 0; k < 5; k++) send(pack(k + 1, 0), k == 4);
        check("early last addr", {61'd0, coef_addr}, 64'd0);
        for (int k = 0; k < FL; k++) send(pack(k + 100, 1), k == FL - 1);
        drain();
        check("early last err count", 64'(err_total - e0), 64'd1);

        // missing last: eight beats with no s_tlast
        e0 = err_total;
        for (int k = 0; k < FL; k++) send(pack(k - 50, 3), 1'b0);
        check("missing last wrap", {61'd0, coef_addr}, 64'd0);
        for (int k = 0; k < FL; k++) send(pack(k + 7, -2), k == FL - 1);
        drain();
        check("missing last err count", 64'(err_total - e0), 64'd1);
`ifdef WFUNC_ERR_CNT_EN
        check("err_cnt value", {48'd0, err_cnt}, 64'(err_total));
`endif

        // reset with beats in flight
        for (int k = 0; k < 3; k++) send(pack(k + 900, k), 1'b0);
        @(posedge clk);
        #1;
        check("pre-reset m_tvalid", {63'd0, m_tvalid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("async reset m_tvalid", {63'd0, m_tvalid}, 64'd0);
        check("async reset coef_addr", {61'd0, coef_addr}, 64'd0);
`ifdef WFUNC_ERR_CNT_EN
        check("async reset err_cnt", {48'd0, err_cnt}, 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < FL; k++) send(pack(-k, k + 5), k == FL - 1);
        drain();

`ifdef WFUNC_ERR_CNT_EN
        for (int k = 0; k < 2; k++) send(pack(k, k), k == 1);
        drain();
        check("err_cnt after early last", {48'd0, err_cnt}, 64'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("err_cnt cleared", {48'd0, err_cnt}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
